// File: rtl/lab_practical.sv
// Four-function ALU for the lab-practical board: pushbutton-selected ADD/SUB/AND/XOR
// on two unsigned operands, with a registered result plus carry/borrow and zero flags.
module lab_practical #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushbutton_one,
  input  logic             pushbutton_two,
  input  logic             pushbutton_three,
  input  logic             pushbutton_four,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_XOR
  } op_e;

  op_e              op;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] next_result;
  logic             next_carry;

  // Fixed priority: one > two > three > four; lower buttons are ignored.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op = OP_NONE;
    if (pushbutton_one)        op = OP_ADD;
    else if (pushbutton_two)   op = OP_SUB;
    else if (pushbutton_three) op = OP_AND;
    else if (pushbutton_four)  op = OP_XOR;
  end

  // Zero-extending by one bit puts the carry-out (ADD) or borrow (SUB, A < B) in the MSB.
  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign diff_ext = {1'b0, A} - {1'b0, B};

  always_comb begin
    next_result = '0;
    next_carry  = 1'b0;
    unique case (op)
      OP_ADD: begin
        next_result = sum_ext[WIDTH-1:0];
        next_carry  = sum_ext[WIDTH];
      end
      OP_SUB: begin
        next_result = diff_ext[WIDTH-1:0];
        next_carry  = diff_ext[WIDTH];
      end
      OP_AND:  next_result = A & B;
      OP_XOR:  next_result = A ^ B;
      OP_NONE: next_result = '0;
      default: next_result = '0;
    endcase
  end

  // With no button held the flags and result simply keep their last values.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b1;
    end else if (op != OP_NONE) begin
      result <= next_result;
      carry  <= next_carry;
      zero   <= (next_result == '0);
    end
  end

endmodule

// File: tb/tb_lab_practical.sv
// Self-checking bench for lab_practical: an integer-arithmetic reference model compared
// every cycle, plus directed vectors with hand-computed expectations.
module tb_lab_practical;

  localparam int WIDTH = 4;
  localparam int MODV  = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       pb;  // pb[0]=one, pb[1]=two, pb[2]=three, pb[3]=four
  logic [WIDTH-1:0] a_in, b_in;
  logic [WIDTH-1:0] result;
  logic             carry, zero;

  int checks = 0;
  int errors = 0;

  int m_res;
  int m_carry;
  int m_zero;
  bit model_valid = 1'b0;

  lab_practical #(.WIDTH(WIDTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .pushbutton_one   (pb[0]),
    .pushbutton_two   (pb[1]),
    .pushbutton_three (pb[2]),
    .pushbutton_four  (pb[3]),
    .A                (a_in),
    .B                (b_in),
    .result           (result),
    .carry            (carry),
    .zero             (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation rules.
  always @(posedge clk) begin
    int ai, bi, r;
    ai = int'(a_in);
    bi = int'(b_in);
    if (rst) begin
      m_res = 0; m_carry = 0; m_zero = 1;
      model_valid = 1'b1;
    end else if (pb != 4'b0000) begin
      if (pb[0]) begin
        r = (ai + bi) % MODV; m_carry = ((ai + bi) >= MODV) ? 1 : 0;
      end else if (pb[1]) begin
        r = (ai - bi + MODV) % MODV; m_carry = (ai < bi) ? 1 : 0;
      end else if (pb[2]) begin
        r = ai & bi; m_carry = 0;
      end else begin
        r = ai ^ bi; m_carry = 0;
      end
      m_res  = r;
      m_zero = (r == 0) ? 1 : 0;
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("model_result", 32'(result), 32'(m_res));
      check("model_carry",  32'(carry),  32'(m_carry));
      check("model_zero",   32'(zero),   32'(m_zero));
    end
  end

  task automatic drive(input logic r, input logic [3:0] p,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(posedge clk);
    #2;
    rst = r; pb = p; a_in = a; b_in = b;
  endtask

  task automatic expect_out(input string name, input logic [WIDTH-1:0] er,
                            input logic ec, input logic ez);
    @(posedge clk);
    #1;
    check({name, "_result"}, 32'(result), 32'(er));
    check({name, "_carry"},  32'(carry),  32'(ec));
    check({name, "_zero"},   32'(zero),   32'(ez));
  endtask

  initial begin
    rst = 1'b1; pb = 4'b0001; a_in = 4'd3; b_in = 4'd1;
    @(posedge clk);
    expect_out("reset", 4'b0000, 1'b0, 1'b1);

    drive(1'b0, 4'b0001, 4'b0011, 4'b0001); expect_out("add_basic", 4'b0100, 1'b0, 1'b0);
    drive(1'b0, 4'b0001, 4'b1111, 4'b0001); expect_out("add_ovf",   4'b0000, 1'b1, 1'b1);
    drive(1'b0, 4'b0001, 4'b1000, 4'b1000); expect_out("add_ovf2",  4'b0000, 1'b1, 1'b1);
    drive(1'b0, 4'b0010, 4'b0001, 4'b0011); expect_out("sub_borrow", 4'b1110, 1'b1, 1'b0);
    drive(1'b0, 4'b0010, 4'b0101, 4'b0101); expect_out("sub_equal",  4'b0000, 1'b0, 1'b1);
    drive(1'b0, 4'b0100, 4'b1100, 4'b1010); expect_out("and",        4'b1000, 1'b0, 1'b0);
    drive(1'b0, 4'b1000, 4'b1100, 4'b1010); expect_out("xor",        4'b0110, 1'b0, 1'b0);
    drive(1'b0, 4'b1100, 4'b1100, 4'b1010); expect_out("prio_3_4",   4'b1000, 1'b0, 1'b0);
    drive(1'b0, 4'b0011, 4'b0011, 4'b0001); expect_out("prio_1_2",   4'b0100, 1'b0, 1'b0);

    // Hold and operand tracking
    drive(1'b0, 4'b0001, 4'b0011, 4'b0001); expect_out("hold_add",   4'b0100, 1'b0, 1'b0);
    drive(1'b0, 4'b0001, 4'b0011, 4'b0010); expect_out("track_b",    4'b0101, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 4'b1111, 4'b1111); expect_out("release",    4'b0101, 1'b0, 1'b0);
    expect_out("release2", 4'b0101, 1'b0, 1'b0);

    // Held carry survives a release; zero result held too
    drive(1'b0, 4'b0001, 4'b1111, 4'b0010); expect_out("add_c",      4'b0001, 1'b1, 1'b0);
    drive(1'b0, 4'b0000, 4'b0000, 4'b0000); expect_out("hold_carry", 4'b0001, 1'b1, 1'b0);
    drive(1'b0, 4'b0010, 4'b0111, 4'b0111); expect_out("sub_zero",   4'b0000, 1'b0, 1'b1);
    drive(1'b0, 4'b0000, 4'b0001, 4'b0000); expect_out("hold_zero",  4'b0000, 1'b0, 1'b1);

    // Reset overrides a pressed button
    drive(1'b0, 4'b0001, 4'b0110, 4'b0011); expect_out("pre_rst",    4'b1001, 1'b0, 1'b0);
    drive(1'b1, 4'b0001, 4'b1111, 4'b0001); expect_out("rst_prio",   4'b0000, 1'b0, 1'b1);

    // Sweep a few operand pairs through every operation; checked by the model only
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'(1 << (i % 4)), 4'(i * 5 + 3), 4'(i * 7 + 1));
    end
    drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab_practical.md
Name: lab_practical

Overview:
Four-function 4-bit arithmetic/logic unit driven by four active-high pushbuttons. Each cycle, the highest-priority pressed button selects an operation on operands A and B. The result is registered with carry and zero flags. It is the top-level datapath of the lab-practical board design, sitting between the switch/button inputs and the LED display.

Parameters:
WIDTH, 4, operand and result width in bits. All behaviour below is stated for WIDTH=4 and scales linearly.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
pushbutton_one  input  1  active-high; selects ADD
pushbutton_two  input  1  active-high; selects SUB
pushbutton_three  input  1  active-high; selects AND
pushbutton_four  input  1  active-high; selects XOR
A  input  WIDTH  operand A, unsigned
B  input  WIDTH  operand B, unsigned
result  output  WIDTH  registered operation result
carry  output  1  registered carry (ADD) / borrow (SUB) flag
zero  output  1  registered flag, 1 when result is all zeros

Behaviour:
- One clock and a synchronous active-high reset, as already decided; no asynchronous logic.
- Reset: on a rising clk edge with rst=1, result=0, carry=0 and zero=1. rst has priority over all buttons.
- Button priority when more than one button is high: one > two > three > four. Lower-priority buttons are ignored.
- Buttons are level-sensitive, with no edge detection and no debounce in this block. While a button is held, the result is recomputed every cycle from the current A and B, so operand changes are tracked.
- Operations, computed combinationally and captured at the next rising edge:
  - one (ADD): result = (A+B) mod 2^WIDTH; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - two (SUB): result = (A-B) mod 2^WIDTH (two's-complement wrap); carry = 1 iff A < B (borrow).
  - three (AND): result = A & B; carry = 0.
  - four (XOR): result = A ^ B; carry = 0.
- zero = 1 iff the value being loaded into result is 0. It is registered in the same cycle as result.
- No button pressed: result, carry and zero hold their previous values.
- Latency: one clock from inputs to outputs. Outputs are stable between edges and free of glitches.
- A, B and the buttons are treated as synchronous to clk. The integrating level supplies synchronizers and debouncers.

Test Plan:
- Reset: assert rst for 2 cycles with button one high, A=3, B=1 -> result=0000, carry=0, zero=1.
- Basic add: button one, A=0011, B=0001, wait one edge -> result=0100, carry=0, zero=0.
- Add overflow: button one, A=1111, B=0001 -> result=0000, carry=1, zero=1. With A=1000, B=1000 -> result=0000, carry=1.
- Subtract with borrow: button two, A=0001, B=0011 -> result=1110, carry=1. With A=0101, B=0101 -> result=0000, carry=0, zero=1.
- Logic and priority: button three, A=1100, B=1010 -> 1000. Button four alone -> 0110, carry=0. Buttons three and four together -> 1000 (three wins). Buttons one and two together with A=0011, B=0001 -> 0100 (one wins).
- Hold and tracking: press button one, A=0011, B=0001 -> 0100. Change B to 0010 while still held -> next edge 0101. Release all buttons and change A and B -> result stays 0101 and flags are unchanged.
